key_sched_ctrl: RTL and testbench

//  AES-256 key-schedule controller sitting directly upstream of GenSubKey.
//  - Takes a 256-bit cipher key and drives GenSubKey once per double-round,

---
 rtl/aes_pkg.sv | 29 ++
 rtl/key_sched_ctrl_if.sv | 30 +++
 rtl/key_sched_ctrl.sv | 172 +++++++++++++++++
 tb/tb_key_sched_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule constants.
//   KEY_LEN / WORD_LEN / NR / NUM_RK : geometry of the key schedule.
//   RK_W        : width of one stored round key (128).
//   TIMEOUT_CYC : WAIT watchdog limit, used only when KEYSCHED_TIMEOUT_EN is defined.
//   ST_*        : controller state encoding.
//   RCON_BASE   : first Rcon byte; later bytes are left shifts of it.
package aes_pkg;
    localparam int KEY_LEN     = 256;
    localparam int WORD_LEN    = 32;
    localparam int NR          = 14;
    localparam int NUM_RK      = NR + 1;
    localparam int RK_W        = KEY_LEN / 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int LAST_ITER   = 6;

    localparam logic [7:0] RCON_BASE = 8'h01;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_STORE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Rcon word as GenSubKey expects it: byte in the top lane.
    function automatic logic [WORD_LEN-1:0] rcon_word(input logic [7:0] rcon_byte);
        return {rcon_byte, 24'h0};
    endfunction
endpackage

// File: rtl/key_sched_ctrl_if.sv
// Handshake bus between key_sched_ctrl and GenSubKey.
//   gen_data   : previous 256-bit key      (controller -> GenSubKey data_in)
//   gen_valid  : 1-cycle request pulse     (controller -> GenSubKey valid_in)
//   gen_rcon   : {rcon_byte, 24'h0}        (controller -> GenSubKey Rcon)
//   gen_result : next 256-bit key          (GenSubKey data_out -> controller)
//   gen_done   : result valid              (GenSubKey valid_out -> controller)
// Modports: master = key_sched_ctrl side, slave = GenSubKey side.
interface key_sched_ctrl_if;
    logic [aes_pkg::KEY_LEN-1:0]  gen_data;
    logic                         gen_valid;
    logic [aes_pkg::WORD_LEN-1:0] gen_rcon;
    logic [aes_pkg::KEY_LEN-1:0]  gen_result;
    logic                         gen_done;

    modport master (
        output gen_data,
        output gen_valid,
        output gen_rcon,
        input  gen_result,
        input  gen_done
    );

    modport slave (
        input  gen_data,
        input  gen_valid,
        input  gen_rcon,
        output gen_result,
        output gen_done
    );
endinterface

// File: rtl/key_sched_ctrl.sv
// AES-256 key-schedule controller.
// Expands a 256-bit cipher key by driving GenSubKey once per double-round
// (7 iterations), stores the 15 round keys and serves them through a
// registered read port.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low reset
//   key_in      : cipher key, [255:128]=w0..w3, [127:0]=w4..w7
//   start       : 1-cycle expand request, ignored while busy
//   busy        : expansion in progress
//   keys_ready  : all round keys valid; cleared by the next accepted start
//   gen         : GenSubKey handshake bus (master side)
//   rk_idx      : round-key read index 0..14
//   rk_data     : round key rk_idx, one cycle after the index
//   timeout_err : sticky watchdog error (KEYSCHED_TIMEOUT_EN), else 0
// Build option: define KEYSCHED_TIMEOUT_EN to enable the WAIT watchdog.
module key_sched_ctrl
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_LEN-1:0]  key_in,
    input  logic                start,
    output logic                busy,
    output logic                keys_ready,
    key_sched_ctrl_if.master    gen,
    input  logic [3:0]          rk_idx,
    output logic [RK_W-1:0]     rk_data,
    output logic                timeout_err
);

    logic [2:0]         state_reg;
    logic [KEY_LEN-1:0] cur_key_reg;
    logic [KEY_LEN-1:0] res_reg;
    logic [2:0]         iter_reg;
    logic [7:0]         rcon_reg;
    logic               busy_reg;
    logic               ready_reg;
    logic [RK_W-1:0]    rk_data_reg;
    logic [RK_W-1:0]    rk_mem [NUM_RK];
    logic [KEY_LEN-1:0] wr_src;
    logic               timeout_hit;

`ifdef KEYSCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt_reg;
    logic            timeout_err_reg;

    // Fires on the TIMEOUT_CYC-th consecutive WAIT cycle without gen_done.
    assign timeout_hit = (state_reg == ST_WAIT) && !gen.gen_done &&
                         (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_WAIT && !gen.gen_done)
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            else
                wd_cnt_reg <= '0;
            if (timeout_hit)
                timeout_err_reg <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cur_key_reg <= '0;
            res_reg     <= '0;
            iter_reg    <= '0;
            rcon_reg    <= RCON_BASE;
            busy_reg    <= 1'b0;
            ready_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        cur_key_reg <= key_in;
                        busy_reg    <= 1'b1;
                        ready_reg   <= 1'b0;
                        iter_reg    <= '0;
                        rcon_reg    <= RCON_BASE;
                        state_reg   <= ST_LOAD;
                    end
                end
                ST_LOAD:  state_reg <= ST_ISSUE;
                ST_ISSUE: state_reg <= ST_WAIT;
                ST_WAIT: begin
                    // GenSubKey may only hold data_out while valid_out is high,
                    // so the result is captured here and consumed in STORE.
                    if (gen.gen_done) begin
                        res_reg   <= gen.gen_result;
                        state_reg <= ST_STORE;
                    end else if (timeout_hit) begin
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_STORE: begin
                    cur_key_reg <= res_reg;
                    iter_reg    <= iter_reg + 3'd1;
                    rcon_reg    <= {rcon_reg[6:0], 1'b0};
                    state_reg   <= (iter_reg == 3'(LAST_ITER)) ? ST_DONE : ST_ISSUE;
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // LOAD writes the cipher key halves; STORE writes the GenSubKey result halves.
    assign wr_src = (state_reg == ST_LOAD) ? cur_key_reg : res_reg;

    // Entry gi is written in STORE when gi is 2*iter+2 or 2*iter+3, i.e.
    // gi/2 == iter+1. Entry 15 does not exist, so the final iteration's
    // lower half is dropped without an explicit bound check.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RK; gi++) begin : g_rk
            logic            entry_we;
            logic [RK_W-1:0] entry_reg;

            always_comb begin
                entry_we = 1'b0;
                if (state_reg == ST_LOAD && gi < 2)
                    entry_we = 1'b1;
                else if (state_reg == ST_STORE && (gi / 2) == (int'(iter_reg) + 1))
                    entry_we = 1'b1;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    entry_reg <= '0;
                else if (entry_we)
                    entry_reg <= (gi % 2 == 0) ? wr_src[KEY_LEN-1 -: RK_W] : wr_src[RK_W-1:0];
            end

            assign rk_mem[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rk_data_reg <= '0;
        else
            rk_data_reg <= (rk_idx < 4'(NUM_RK)) ? rk_mem[rk_idx] : '0;
    end

    // gen_data/gen_rcon stay constant from ISSUE through the whole WAIT.
    assign gen.gen_data  = cur_key_reg;
    assign gen.gen_valid = (state_reg == ST_ISSUE);
    assign gen.gen_rcon  = (state_reg == ST_ISSUE || state_reg == ST_WAIT) ?
                           rcon_word(rcon_reg) : '0;

    assign busy       = busy_reg;
    assign keys_ready = ready_reg;
    assign rk_data    = rk_data_reg;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Testbench for key_sched_ctrl with a behavioural GenSubKey responder
// (random latency) and an AES-256 word-level key-expansion reference.
module tb_key_sched_ctrl;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] key_in;
    logic         start;
    logic         busy;
    logic         keys_ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         timeout_err;

    always #5 clk = ~clk;

    key_sched_ctrl_if gen_bus();

    key_sched_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .key_in      (key_in),
        .start       (start),
        .busy        (busy),
        .keys_ready  (keys_ready),
        .gen         (gen_bus),
        .rk_idx      (rk_idx),
        .rk_data     (rk_data),
        .timeout_err (timeout_err)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- AES helpers ----------------
    logic [7:0] sbox_tbl [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a = a_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t = {v, v};
        t = t << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] b);
        logic [7:0] inv = 8'h01;
        if (b == 8'h00) inv = 8'h00;
        else for (int e = 0; e < 254; e++) inv = gmul(inv, b);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
    endfunction

    // GenSubKey stand-in: one double-round step from the previous 8 words.
    function automatic logic [255:0] gen_step(input logic [255:0] prev, input logic [7:0] rc);
        logic [31:0] p [8];
        logic [31:0] n [8];
        for (int k = 0; k < 8; k++) p[k] = prev[255 - 32*k -: 32];
        n[0] = p[0] ^ sub_word({p[7][23:0], p[7][31:24]}) ^ {rc, 24'h0};
        n[1] = p[1] ^ n[0];
        n[2] = p[2] ^ n[1];
        n[3] = p[3] ^ n[2];
        n[4] = p[4] ^ sub_word(n[3]);
        n[5] = p[5] ^ n[4];
        n[6] = p[6] ^ n[5];
        n[7] = p[7] ^ n[6];
        return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
    endfunction

    // Reference: textbook AES-256 expansion over the 60-word schedule.
    logic [127:0] exp_rk [15];

    task automatic ref_expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            temp = w[i-1];
            if (i % 8 == 0) begin
                rc   = 8'h01 << (i/8 - 1);
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
            end else if (i % 8 == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-8] ^ temp;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- GenSubKey responder ----------------
    logic [255:0] held_data;
    logic [7:0]   held_rcon;
    int           lat;
    bit           pending  = 1'b0;
    bit           mute     = 1'b0;
    bit           spurious = 1'b0;
    int           valid_cnt = 0;
    logic [7:0]   rcon_seen [$];

    initial begin
        gen_bus.gen_done   = 1'b0;
        gen_bus.gen_result = '0;
        forever begin
            @(negedge clk);
            gen_bus.gen_done = 1'b0;
            if (reset !== 1'b1) begin
                pending = 1'b0;
            end else if (spurious) begin
                gen_bus.gen_result = {8{$urandom()}};
                gen_bus.gen_done   = 1'b1;
                spurious = 1'b0;
            end else if (pending) begin
                lat--;
                if (lat <= 0 && !mute) begin
                    chk("gen_data_hold", gen_bus.gen_data, held_data);
                    chk("gen_rcon_hold", gen_bus.gen_rcon, {held_rcon, 24'h0});
                    gen_bus.gen_result = gen_step(gen_bus.gen_data, gen_bus.gen_rcon[31:24]);
                    gen_bus.gen_done   = 1'b1;
                    pending = 1'b0;
                end
            end else if (gen_bus.gen_valid) begin
                pending   = 1'b1;
                held_data = gen_bus.gen_data;
                held_rcon = gen_bus.gen_rcon[31:24];
                lat       = $urandom_range(1, 6);
                valid_cnt++;
                rcon_seen.push_back(held_rcon);
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic read_rk(input int idx, output logic [127:0] d);
        @(negedge clk);
        rk_idx = 4'(idx);
        @(negedge clk);
        d = rk_data;
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic run_and_check(input logic [255:0] key, input bit poke);
        logic [127:0] d;
        logic [7:0]   got_rc;
        logic [7:0]   exp_rc;
        int           n = 0;
        ref_expand(key);
        valid_cnt = 0;
        rcon_seen.delete();
        @(negedge clk);
        key_in = key;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = rand_key();
        chk("busy_after_start", busy, 1);
        chk("ready_cleared", keys_ready, 0);
        if (poke) begin
            repeat (4) @(negedge clk);
            key_in = rand_key();
            start  = 1'b1;
            @(negedge clk);
            start  = 1'b0;
        end
        while (!keys_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("keys_ready", keys_ready, 1);
        chk("busy_done", busy, 0);
        chk("gen_valid_pulses", valid_cnt, 7);
        for (int k = 0; k < 7; k++) begin
            exp_rc = 8'h01 << k;
            got_rc = (rcon_seen.size() > k) ? rcon_seen[k] : 8'h00;
            chk($sformatf("rcon%0d", k), got_rc, exp_rc);
        end
        for (int r = 0; r < 15; r++) begin
            read_rk(r, d);
            chk($sformatf("rk%0d", r), d, exp_rk[r]);
        end
        read_rk(15, d);
        chk("rk15_zero", d, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [127:0] d;
        logic [255:0] fips_key;
        int           pulses;
        int           n;

        for (int x = 0; x < 256; x++) sbox_tbl[x] = sbox_calc(8'(x));

        reset  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        rk_idx = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_keys_ready", keys_ready, 0);
        chk("rst_rk_data", rk_data, 0);
        chk("rst_gen_valid", gen_bus.gen_valid, 0);
        chk("rst_gen_rcon", gen_bus.gen_rcon, 0);
        chk("rst_timeout_err", timeout_err, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // FIPS-197 AES-256 key, plus its published round keys.
        fips_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        run_and_check(fips_key, 1'b0);
        read_rk(0, d);
        chk("fips_rk0", d, 128'h000102030405060708090a0b0c0d0e0f);
        read_rk(1, d);
        chk("fips_rk1", d, 128'h101112131415161718191a1b1c1d1e1f);
        read_rk(2, d);
        chk("fips_rk2", d, 128'ha573c29fa176c498a97fce93a572c09c);
        read_rk(14, d);
        chk("fips_rk14", d, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // start re-pulsed while busy must not disturb the expansion
        run_and_check(fips_key, 1'b1);

        for (int t = 0; t < 3; t++) run_and_check(rand_key(), 1'b0);

        // reset in the middle of a WAIT
        @(negedge clk);
        key_in = rand_key();
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        n      = 0;
        while (pulses < 2 && n < 200) begin
            @(negedge clk);
            if (gen_bus.gen_valid) pulses++;
            n++;
        end
        chk("reached_second_issue", pulses, 2);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy_async", busy, 0);
        chk("midrst_ready_async", keys_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("midrst_gen_rcon", gen_bus.gen_rcon, 0);
        read_rk(0, d);
        chk("midrst_rk0", d, 0);
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        chk("stale_done_busy", busy, 0);
        read_rk(2, d);
        chk("stale_done_rk2", d, 0);
        run_and_check(rand_key(), 1'b0);

`ifdef KEYSCHED_TIMEOUT_EN
        mute = 1'b1;
        @(negedge clk);
        key_in = rand_key();
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n = 0;
        while (!gen_bus.gen_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_issue_seen", gen_bus.gen_valid, 1);
        n = 0;
        while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", n, TIMEOUT_CYC + 1);
        chk("timeout_err_set", timeout_err, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_ready", keys_ready, 0);
        repeat (3) @(negedge clk);
        chk("timeout_sticky", timeout_err, 1);
        reset = 1'b0;
        mute  = 1'b0;
        @(negedge clk);
        chk("timeout_cleared", timeout_err, 0);
        reset = 1'b1;
        run_and_check(rand_key(), 1'b0);
`else
        chk("timeout_tied_low", timeout_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
